// File: rtl/shift_reg_frame_sequencer_pkg.sv
// Shared definitions for the shift-register frame sequencer.
//   - Default word/register width.
//   - 3-bit state encoding and the FSM state type.
//   - Helper for sizing small counters that must be at least one bit wide.
package shift_reg_frame_sequencer_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE,
    GAP   = ST_GAP
  } state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_frame_sequencer_if.sv
// Word input handshake of the frame sequencer.
//   in_valid      producer has a word
//   in_data       word to serialize (DATA_W bits)
//   in_lsb_first  1: send bit0 first, 0: send MSB first
//   in_ready      sequencer can take a word this cycle
// Modports: master = word producer, slave = sequencer.
interface shift_reg_frame_sequencer_if
  import shift_reg_frame_sequencer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_lsb_first;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_lsb_first,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_lsb_first,
    output in_ready
  );

endinterface

// File: rtl/shift_reg_frame_sequencer.sv
// Sequences an external load/shift register so that whole words leave it
// serially. Each accepted word is loaded for one cycle, then exactly DATA_W
// shift cycles follow with one serial bit per cycle, then a one-cycle
// frame_done pulse and an optional idle gap before the next word.
// The register has no hold mode, so all load timing is owned here.
// Ports:
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   in_if          word handshake (slave side)
//   abort          synchronous frame cancel, highest priority
//   reg_load_n     register load enable, active-low
//   reg_dir        register direction: 0 shift left, 1 shift right
//   reg_d          register parallel input
//   reg_q          register parallel output
//   ser_valid      ser_bit carries a frame bit this cycle
//   ser_bit        current serial bit
//   busy           sequencer not idle
//   frame_done     one-cycle pulse after the last bit
//   frame_cnt      completed (non-aborted) frames, wraps
module shift_reg_frame_sequencer
  import shift_reg_frame_sequencer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int GAP_CYCLES = 0,
  parameter int FCNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  shift_reg_frame_sequencer_if.slave in_if,
  input  logic                       abort,
  output logic                       reg_load_n,
  output logic                       reg_dir,
  output logic [DATA_W-1:0]          reg_d,
  input  logic [DATA_W-1:0]          reg_q,
  output logic                       ser_valid,
  output logic                       ser_bit,
  output logic                       busy,
  output logic                       frame_done,
  output logic [FCNT_W-1:0]          frame_cnt
);

  localparam int BCNT_W = $clog2(DATA_W);
  localparam int GCNT_W = cnt_w(GAP_CYCLES + 1);

  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [GCNT_W-1:0]   gap_cnt;
  logic                in_shift;
  logic                unused_reg_q;

  // Only the two end bits of the register are ever observed.
  assign unused_reg_q = ^reg_q;

  assign in_shift  = (state == SHIFT);
  assign busy      = (state != IDLE);
  assign ser_valid = in_shift;
  assign ser_bit   = in_shift & (reg_dir ? reg_q[0] : reg_q[DATA_W-1]);

  // Held high during reset so the producer sees a ready sink; the flops are
  // held in reset, so nothing is actually taken.
  assign in_if.in_ready = !reset_n || ((state == IDLE) && !abort);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      reg_load_n <= 1'b1;
      reg_dir    <= 1'b0;
      reg_d      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      // Load strobe and done pulse are single-cycle; re-asserted only on
      // the transition that enters LOAD or DONE.
      reg_load_n <= 1'b1;
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (in_if.in_valid) begin
              reg_d      <= in_if.in_data;
              reg_dir    <= in_if.in_lsb_first;
              reg_load_n <= 1'b0;
              state      <= LOAD;
            end
          end
          LOAD: begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              // Count moves together with the pulse, so an abort during
              // DONE cannot take the frame back.
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + FCNT_W'(1);
              state      <= DONE;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
          DONE: begin
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GCNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
